localstore_pipe: RTL and testbench
==================================

Name: localstore_pipe

Overview:
- Parametrised next-generation SPU local store: single-port quadword memory, configurable size, forward-pipe latency and unit ID.
- Effective address is computed upstream by the decode/address stage, not in this block.
- Adds a DMA side port that uses idle SPU cycles, with SPU-priority arbitration.
- Load results leave on the standard 139-bit forwarding bus: data[0:127], unit[128:130], wr_valid[131], rt[132:138].

Parameters:
- LS_BYTES, 256, memory size in bytes; power of two, >= 16.
- LAT, 6, cycles from load issue to load result on fw_out; >= 2.
- UNIT_ID, 6, 3-bit unit tag written into fw_out[128:130] for load results.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- op  in  2  0 = idle, 1 = load quadword, 2 = store quadword, 3 = reserved (treated as idle)
- addr  in  32  effective byte address from address stage
- wdata  in  128  store data (rt value), byte 0 = bits [0:7]
- rt_addr  in  7  destination register of a load
- fw_out  out  139  forwarding-pipe tail: {data, unit, wr_valid, rt}
- dma_req  in  1  DMA requests an access this cycle
- dma_we  in  1  1 = DMA quadword write, 0 = DMA quadword read
- dma_addr  in  32  DMA byte address
- dma_wdata  in  128  DMA write data
- dma_gnt  out  1  combinational: DMA access accepted this cycle
- dma_rvalid  out  1  registered: DMA read data valid
- dma_rdata  out  128  DMA read data

Behaviour:
- Clocking and reset: one clock, clk. Reset is synchronous and active-high.
- Address rules:
  - Index = addr[31-log2(LS_BYTES)+1 : 31] with the low 4 bits forced to 0, so addresses are quadword aligned.
  - Upper address bits are ignored, so addresses wrap modulo LS_BYTES. The same rule applies to dma_addr.
- Store (op = 2), cycle N:
  - The 16 bytes of wdata are written at the clk edge ending cycle N.
  - The store emits a zero bubble into the pipe (stage 1 = all zeros).
- Load (op = 1), cycle N:
  - The memory is read at the edge ending cycle N.
  - Stage 1 = {data, UNIT_ID, 1'b1, rt_addr}.
  - Stages 2..LAT shift one per cycle; fw_out = stage LAT, valid during cycle N+LAT.
  - A load always sees every store or DMA write issued in an earlier cycle.
- Idle/reserved op: stage 1 = 0.
- Pipeline: fully pipelined, one op per cycle, no stalls; every stage advances every cycle.
- DMA arbitration:
  - dma_gnt = dma_req & (op is idle or reserved) & ~reset. The SPU always wins.
  - A DMA requester holds dma_req and its fields until it sees dma_gnt.
- Granted DMA write: memory updated at the end of that cycle.
- Granted DMA read:
  - dma_rvalid = 1 and dma_rdata = quadword in the following cycle.
  - dma_rvalid = 0 otherwise; dma_rdata holds its last value.
- Reset (cycle with reset = 1):
  - All pipe stages and fw_out cleared to 0; dma_rvalid = 0; dma_rdata = 0.
  - In-flight loads are discarded.
  - op and DMA accesses in a reset cycle are ignored, with no memory write.
  - First op accepted in the cycle after reset deasserts.
- Memory contents on reset: governed by the optional feature.
- Simultaneous SPU op and DMA request: the DMA waits; no memory conflict is possible.

Optional Feature:
- Macro: LS_INIT_EN.
- Defined: a reset cycle also initialises memory. Each 32-bit big-endian word k (byte address 4k) is set to value k, e.g. the quadword at 0x20 holds words 8, 9, 10, 11.
- Not defined: reset leaves memory contents untouched. Memory is uninitialised (X) at power-up.

Test Plan:
1. LS_INIT_EN defined, reset for 1 cycle, then load addr 0x20, rt_addr 5 at cycle N -> during cycle N+6, fw_out = {0x00000008_00000009_0000000A_0000000B, 3'd6, 1, 7'd5}; fw_out = 0 in all other cycles.
2. Store addr 0x40, wdata 0x0123..CDEF at N; load 0x40 at N+1 -> fw_out at N+7 carries the stored data; the cycle N+6 slot is zero.
3. Load addr 0x4B and load addr 0x140 (LS_BYTES = 256) -> both return the quadword at 0x40.
4. Back-to-back loads to 0x00, 0x10, 0x20 -> three consecutive fw_out results at N+6, N+7, N+8 with the correct rt tags.
5. dma_req read 0x30 held while op = load -> dma_gnt = 0. Next cycle op = 0 -> dma_gnt = 1, then dma_rvalid = 1 with the 0x30 data one cycle later. A DMA write 0x50 followed by SPU load 0x50 returns the DMA data.
6. Load at N, reset asserted at N+2 -> fw_out = 0 through N+8. A store issued in the reset cycle does not modify memory.

Source files
------------

// File: rtl/localstore_pipe.sv
// localstore_pipe: SPU local store with a fixed-latency load forwarding pipe
// and an idle-cycle DMA side port.
// Bit numbering follows the forwarding-bus convention: bit 0 is the MSB.
// fw_out = {data[0:127], unit[128:130], wr_valid[131], rt[132:138]}.
// Optional feature: define LS_INIT_EN so that a reset cycle also fills memory
// with the word-index pattern (32-bit word k holds k).
module localstore_pipe #(
   parameter int LS_BYTES = 256,
   parameter int LAT      = 6,
   parameter int UNIT_ID  = 6
) (
   input  logic           clk,
   input  logic           reset,
   input  logic [1:0]     op,
   input  logic [0:31]    addr,
   input  logic [0:127]   wdata,
   input  logic [0:6]     rt_addr,
   output logic [0:138]   fw_out,
   input  logic           dma_req,
   input  logic           dma_we,
   input  logic [0:31]    dma_addr,
   input  logic [0:127]   dma_wdata,
   output logic           dma_gnt,
   output logic           dma_rvalid,
   output logic [0:127]   dma_rdata
);

   localparam int QW  = LS_BYTES / 16;
   localparam int QAW = (QW > 1) ? $clog2(QW) : 1;
   localparam logic [2:0] UNIT_TAG = 3'(UNIT_ID);

   logic [0:127]   mem [QW];
   logic [0:127]   rd_reg;
   logic           ld_valid_reg;
   logic [0:6]     rt_reg;
   logic           dma_rvalid_reg;
   logic [0:127]   dma_hold_reg;
   logic [0:138]   stage_reg [2:LAT];
   logic [0:138]   stage1;

   logic           spu_busy;
   logic           spu_ld;
   logic           spu_st;
   logic [31:0]    spu_a;
   logic [31:0]    dma_a;
   logic [QAW-1:0] spu_idx;
   logic [QAW-1:0] dma_idx;
   logic [QAW-1:0] port_idx;
   logic           mem_we;
   logic           mem_re;
   logic [0:127]   mem_wd;

   // Address decode: quadword index, upper bits dropped so addresses wrap.
   assign spu_a   = addr;
   assign dma_a   = dma_addr;
   assign spu_idx = QAW'((spu_a >> 4) & 32'(QW - 1));
   assign dma_idx = QAW'((dma_a >> 4) & 32'(QW - 1));

   // Arbitration: the SPU owns the single port whenever it issues a load or store.
   assign spu_busy = (op == 2'd1) || (op == 2'd2);
   assign spu_ld   = !reset && (op == 2'd1);
   assign spu_st   = !reset && (op == 2'd2);
   assign dma_gnt  = dma_req && !spu_busy && !reset;

   assign port_idx = spu_busy ? spu_idx : dma_idx;
   assign mem_we   = spu_st || (dma_gnt && dma_we);
   assign mem_re   = spu_ld || (dma_gnt && !dma_we);
   assign mem_wd   = spu_st ? wdata : dma_wdata;

   // Memory write port (optionally filled with the word-index pattern on reset).
   always_ff @(posedge clk) begin
`ifdef LS_INIT_EN
      if (reset) begin
         for (int q = 0; q < QW; q++) begin
            mem[q[QAW-1:0]] <= {32'(4 * q), 32'(4 * q + 1), 32'(4 * q + 2), 32'(4 * q + 3)};
         end
      end else if (mem_we) begin
         mem[port_idx] <= mem_wd;
      end
`else
      if (mem_we) begin
         mem[port_idx] <= mem_wd;
      end
`endif
   end

   // Registered read shared by SPU loads and DMA reads.
   always_ff @(posedge clk) begin
      if (mem_re) begin
         rd_reg <= mem[port_idx];
      end
   end

   // Side-band state travelling with the read: load tag and DMA read valid/hold.
   always_ff @(posedge clk) begin
      if (reset) begin
         ld_valid_reg   <= 1'b0;
         rt_reg         <= '0;
         dma_rvalid_reg <= 1'b0;
         dma_hold_reg   <= '0;
      end else begin
         ld_valid_reg   <= spu_ld;
         rt_reg         <= rt_addr;
         dma_rvalid_reg <= dma_gnt && !dma_we;
         if (dma_rvalid_reg) begin
            dma_hold_reg <= rd_reg;
         end
      end
   end

   // Stage 1 is the read register itself, masked to zero for bubbles.
   assign stage1 = ld_valid_reg ? {rd_reg, UNIT_TAG, 1'b1, rt_reg} : '0;

   // Stages 2..LAT: plain shift register, cleared on reset to drop in-flight loads.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 2; i <= LAT; i++) begin
            stage_reg[i] <= '0;
         end
      end else begin
         stage_reg[2] <= stage1;
         for (int i = 3; i <= LAT; i++) begin
            stage_reg[i] <= stage_reg[i-1];
         end
      end
   end

   assign fw_out     = stage_reg[LAT];
   assign dma_rvalid = dma_rvalid_reg;
   assign dma_rdata  = dma_rvalid_reg ? rd_reg : dma_hold_reg;

endmodule

// File: tb/tb_localstore_pipe.sv
// tb_localstore_pipe: directed stimulus with a scoreboard of expected
// forwarding-bus and DMA read results, checked every cycle.
module tb_localstore_pipe;

   localparam int LAT = 6;

   logic           clk = 1'b0;
   logic           reset;
   logic [1:0]     op;
   logic [0:31]    addr;
   logic [0:127]   wdata;
   logic [0:6]     rt_addr;
   logic [0:138]   fw_out;
   logic           dma_req;
   logic           dma_we;
   logic [0:31]    dma_addr;
   logic [0:127]   dma_wdata;
   logic           dma_gnt;
   logic           dma_rvalid;
   logic [0:127]   dma_rdata;

   typedef struct {int due; logic [0:138] val;} fw_exp_t;
   typedef struct {int due; logic [0:127] d;} dma_exp_t;

   fw_exp_t      fq[$];
   dma_exp_t     dq[$];
   logic [0:127] model [16];
   logic [0:127] dma_last;
   int           cyc = 0;
   bit           armed = 1'b0;
   int           n_pass = 0;
   int           n_total = 0;

   localstore_pipe #(.LS_BYTES(256), .LAT(LAT), .UNIT_ID(6)) dut (
      .clk(clk), .reset(reset), .op(op), .addr(addr), .wdata(wdata),
      .rt_addr(rt_addr), .fw_out(fw_out), .dma_req(dma_req), .dma_we(dma_we),
      .dma_addr(dma_addr), .dma_wdata(dma_wdata), .dma_gnt(dma_gnt),
      .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata)
   );

   always #5 clk = ~clk;

   function automatic int midx(input logic [0:31] a);
      return (int'(a) % 256) / 16;
   endfunction

   function automatic logic [0:127] pat(input int q);
      return {32'(4 * q), 32'(4 * q + 1), 32'(4 * q + 2), 32'(4 * q + 3)};
   endfunction

   task automatic check(input string tag, input logic [0:138] got, input logic [0:138] exp);
      n_total++;
      assert (got === exp) n_pass++;
      else $error("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
   endtask

   // Advance one cycle and compare outputs against the scoreboard.
   task automatic tick();
      fw_exp_t  f;
      dma_exp_t e;
      logic [0:138] fw_exp;
      @(posedge clk);
      #1;
      cyc++;
      if (armed) begin
         fw_exp = '0;
         if (fq.size() > 0 && fq[0].due == cyc) begin
            f = fq.pop_front();
            fw_exp = f.val;
         end
         check("fw_out", fw_out, fw_exp);
         if (dq.size() > 0 && dq[0].due == cyc) begin
            e = dq.pop_front();
            check("dma_rvalid", 139'(dma_rvalid), 139'(1));
            check("dma_rdata", 139'(dma_rdata), 139'(e.d));
            dma_last = e.d;
         end else begin
            check("dma_rvalid_idle", 139'(dma_rvalid), 139'(0));
            check("dma_rdata_hold", 139'(dma_rdata), 139'(dma_last));
         end
      end
      $display("cyc=%0d op=%0d addr=%h fw_out=%h gnt=%0b rvalid=%0b", cyc, op, addr, fw_out, dma_gnt, dma_rvalid);
   endtask

   // Drive one SPU op for one cycle (DMA inputs as currently set), update model.
   task automatic issue(input logic [1:0] op_i, input logic [0:31] a_i,
                        input logic [0:127] wd_i, input logic [0:6] rt_i);
      bit gnt_exp;
      op = op_i; addr = a_i; wdata = wd_i; rt_addr = rt_i;
      #1;
      gnt_exp = dma_req && (op_i == 2'd0 || op_i == 2'd3);
      check("dma_gnt", 139'(dma_gnt), 139'(gnt_exp));
      if (op_i == 2'd1) fq.push_back('{cyc + LAT, {model[midx(a_i)], 3'd6, 1'b1, rt_i}});
      if (op_i == 2'd2) model[midx(a_i)] = wd_i;
      if (gnt_exp) begin
         if (dma_we) model[midx(dma_addr)] = dma_wdata;
         else dq.push_back('{cyc + 1, model[midx(dma_addr)]});
      end
      tick();
   endtask

   initial begin
      reset = 1'b1; op = 2'd0; addr = '0; wdata = '0; rt_addr = '0;
      dma_req = 1'b0; dma_we = 1'b0; dma_addr = '0; dma_wdata = '0;
      dma_last = '0;
      for (int q = 0; q < 16; q++) model[q] = 'x;
      tick();
      // Reset state
      armed = 1'b1;
      check("rst_fw_out", fw_out, '0);
      check("rst_dma_rvalid", 139'(dma_rvalid), 139'(0));
      check("rst_dma_rdata", 139'(dma_rdata), 139'(0));
`ifdef LS_INIT_EN
      for (int q = 0; q < 16; q++) model[q] = pat(q);
      reset = 1'b0;
      issue(2'd1, 32'h20, '0, 7'd5);
`endif
      reset = 1'b0;
      // Preload the word-index pattern through SPU stores
      for (int q = 0; q < 16; q++) issue(2'd2, 32'(16 * q), pat(q), '0);
      // Test 1: load 0x20 -> words 8..11, rt 5
      check("pat_0x20", 139'(pat(2)), 139'(128'h00000008_00000009_0000000A_0000000B));
      issue(2'd1, 32'h20, '0, 7'd5);
      for (int i = 0; i < 7; i++) issue(2'd0, '0, '0, '0);
      // Test 2: store then load 0x40
      issue(2'd2, 32'h40, 128'h0123456789ABCDEF_FEDCBA9876543210, '0);
      issue(2'd1, 32'h40, '0, 7'd9);
      // Test 3: unaligned and wrapped addresses hit 0x40
      issue(2'd1, 32'h4B, '0, 7'd10);
      issue(2'd1, 32'h140, '0, 7'd11);
      // Test 4: back-to-back loads
      issue(2'd1, 32'h00, '0, 7'd1);
      issue(2'd1, 32'h10, '0, 7'd2);
      issue(2'd1, 32'h20, '0, 7'd3);
      // Test 5: DMA read blocked by a load, then granted on idle
      dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'h30;
      issue(2'd1, 32'h10, '0, 7'd4);
      issue(2'd0, '0, '0, '0);
      dma_req = 1'b0;
      issue(2'd0, '0, '0, '0);
      issue(2'd3, '0, '0, '0);
      // DMA write 0x50 then SPU load 0x50
      dma_req = 1'b1; dma_we = 1'b1; dma_addr = 32'h50;
      dma_wdata = 128'hCAFEBABE_DEADBEEF_00112233_44556677;
      issue(2'd2, 32'h60, 128'h1111_2222_3333_4444_5555_6666_7777_8888, '0);
      issue(2'd0, '0, '0, '0);
      dma_req = 1'b0;
      issue(2'd1, 32'h50, '0, 7'd12);
      issue(2'd1, 32'h60, '0, 7'd13);
      for (int i = 0; i < 8; i++) issue(2'd0, '0, '0, '0);
      // Test 6: reset discards an in-flight load and ignores store/DMA
      issue(2'd1, 32'h00, '0, 7'd14);
      issue(2'd0, '0, '0, '0);
      reset = 1'b1; op = 2'd2; addr = 32'h60; wdata = 128'hFFFF_0000_FFFF_0000_FFFF_0000_FFFF_0000;
      dma_req = 1'b1; dma_we = 1'b1; dma_addr = 32'h70; dma_wdata = 128'h5A5A;
      #1;
      check("rst_dma_gnt", 139'(dma_gnt), 139'(0));
      fq.delete(); dq.delete(); dma_last = '0;
`ifdef LS_INIT_EN
      for (int q = 0; q < 16; q++) model[q] = pat(q);
`endif
      tick();
      reset = 1'b0; dma_req = 1'b0;
      for (int i = 0; i < 7; i++) issue(2'd0, '0, '0, '0);
      issue(2'd1, 32'h60, '0, 7'd15);
      issue(2'd1, 32'h70, '0, 7'd16);
      // Drain, bounded
      for (int i = 0; i < 20 && (fq.size() + dq.size()) > 0; i++) issue(2'd0, '0, '0, '0);
      check("drain_empty", 139'(fq.size() + dq.size()), 139'(0));
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
